// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int ALU_OP_W      = 2;
  localparam int DEFAULT_WIDTH = 8;
  localparam int ID_W          = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_req_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the requester named by prio.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end
    winner = grant[1];
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two requesters; one transaction at a time,
// round-robin on ties, operands and result registered, response tagged with requester id.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [WIDTH-1:0]    req0_a,
  input  logic [WIDTH-1:0]    req0_b,
  input  logic [ALU_OP_W-1:0] req0_op,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [WIDTH-1:0]    req1_a,
  input  logic [WIDTH-1:0]    req1_b,
  input  logic [ALU_OP_W-1:0] req1_op,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [WIDTH-1:0]    alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [WIDTH-1:0]    rsp_data,
  output state_e              dbg_state,
  output logic                dbg_prio
);

  // Valid/ready on every channel: a transfer happens on a rising edge where both are high.
  // Request ready is offered only in IDLE with ena high, to the arbitration winner.

  state_e     state;
  state_e     state_nx;
  logic       prio;
  logic [1:0] grant;
  logic       winner;
  logic       take;
  logic       done;

  rr_pick2 u_pick (
    .valid  ({req1_valid, req0_valid}),
    .prio   (prio),
    .grant  (grant),
    .winner (winner)
  );

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    take       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (ena) begin
          req0_ready = grant[0];
          req1_ready = grant[1];
          take       = |grant;
          if (take) state_nx = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        if (rsp_ready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      prio      <= 1'b0;
    end else begin
      if (take) begin
        alu_a  <= winner ? req1_a  : req0_a;
        alu_b  <= winner ? req1_b  : req0_b;
        alu_op <= winner ? req1_op : req0_op;
        rsp_id <= winner;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_result;
        rsp_valid <= 1'b1;
      end
      // Fairness pointer moves only when a response is consumed.
      if (done) begin
        rsp_valid <= 1'b0;
        prio      <= ~rsp_id;
      end
    end
  end

  assign dbg_state = state;
  assign dbg_prio  = prio;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed scenarios plus random traffic,
// with a negedge monitor that models grants and scores responses against exp_q.
module tb_alu_req_arbiter;
  import alu_arb_pkg::*;

  localparam int W = 8;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [1:0]    req0_op, req1_op;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [1:0]    alu_op;
  logic          rsp_valid, rsp_ready;
  logic          rsp_id;
  logic [W-1:0]  rsp_data;
  state_e        dbg_state;
  logic          dbg_prio;

  alu_req_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .dbg_state  (dbg_state),
    .dbg_prio   (dbg_prio)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ALU model ----------------
  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_op);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [W:0] exp_q[$];
  logic       m_prio;
  logic       m_busy;
  logic [1:0] mon_v;
  logic [1:0] mon_exp;
  logic [W:0] mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_prio = 1'b0;
      m_busy = 1'b0;
    end else begin
      mon_v   = {req1_valid, req0_valid};
      mon_exp = 2'b00;
      if (!m_busy && ena) mon_exp = (mon_v == 2'b11) ? (m_prio ? 2'b10 : 2'b01) : mon_v;
      check("req_ready", {30'd0, req1_ready, req0_ready}, {30'd0, mon_exp});
      if (!m_busy) check("rsp_valid_idle", rsp_valid, 0);
      if (req0_valid && req0_ready) begin
        exp_q.push_back({1'b0, alu_model(req0_a, req0_b, req0_op)});
        m_busy = 1'b1;
      end else if (req1_valid && req1_ready) begin
        exp_q.push_back({1'b1, alu_model(req1_a, req1_b, req1_op)});
        m_busy = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_id", rsp_id, mon_e[W]);
          check("rsp_data", rsp_data, mon_e[W-1:0]);
          m_prio = ~mon_e[W];
        end
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  bit ok;
  int last_cyc;

  initial begin
    rst_n = 1'b0; ena = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_prio", dbg_prio, 0);
    check("rst_ready", {req1_ready, req0_ready}, 0);
    rst_n = 1'b1; ena = 1'b1; rsp_ready = 1'b1;

    // single request from requester 0
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 8'h35; req0_b = 8'h0F; req0_op = 2'b00;
    @(negedge clk);
    check("single_ready0", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req0_a = 8'hAA; req0_b = 8'h55; req0_op = 2'b11;
    check("single_alu_a", alu_a, 8'h35);
    check("single_alu_b", alu_b, 8'h0F);
    check("single_alu_op", alu_op, 0);
    check("single_exec_novalid", rsp_valid, 0);
    check("single_state_exec", dbg_state, EXEC);
    @(posedge clk); #1;
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_id", rsp_id, 0);
    check("single_rsp_data", rsp_data, 8'h44);
    @(posedge clk); #1;
    check("single_done_valid", rsp_valid, 0);
    check("single_done_idle", dbg_state, IDLE);

    // contention from a fresh reset: ids alternate 0,1,0,1 every 3 cycles
    do_reset();
    ena = 1'b1; rsp_ready = 1'b1;
    req0_a = 8'd1; req0_b = 8'd2; req0_op = 2'd0;
    req1_a = 8'd3; req1_b = 8'd4; req1_op = 2'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(ok);
      check("cont_rsp_seen", ok, 1);
      check("cont_id_order", rsp_id, i % 2);
      if (i > 0) check("cont_period", cyc - last_cyc, 3);
      last_cyc = cyc;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // backpressure: response held stable, no new grants
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 8'h09; req1_b = 8'h05; req1_op = 2'd2;
    @(posedge clk); #1;
    req1_valid = 1'b0; req0_valid = 1'b1;
    wait_valid(ok);
    check("bp_valid_seen", ok, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_id", rsp_id, 1);
      check("bp_hold_data", rsp_data, 8'h01);
      check("bp_no_ready", {req1_ready, req0_ready}, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_after", dbg_state, IDLE);
    check("bp_valid_drop", rsp_valid, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // enable gating
    ena = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'h10; req0_b = 8'h20; req1_a = 8'hF0; req1_b = 8'h0F; req0_op = 2'd1; req1_op = 2'd3;
    repeat (4) begin
      @(negedge clk);
      check("ena_no_ready", {req1_ready, req0_ready}, 0);
      check("ena_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    ena = 1'b1;
    @(posedge clk); #1;
    ena = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    check("ena_drop_in_exec", dbg_state, EXEC);
    wait_rsp(ok);
    check("ena_drop_rsp_done", ok, 1);
    check("ena_drop_id", rsp_id, 1);
    @(posedge clk); #1;
    ena = 1'b1;

    // one req0 transaction so prio points at requester 1
    req0_valid = 1'b1; req0_a = 8'h22; req0_b = 8'h11; req0_op = 2'd0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp(ok);
    check("pre_rst_rsp", ok, 1);
    @(posedge clk); #1;
    check("pre_rst_prio", dbg_prio, 1);

    // reset during RESP
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h07; req1_b = 8'h08; req1_op = 2'd3;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_valid(ok);
    check("mid_resp_reached", ok, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_id", rsp_id, 0);
    check("mid_rst_data", rsp_data, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_alu_op", alu_op, 0);
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_prio", dbg_prio, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_no_stale", rsp_valid, 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_rsp(ok);
    check("post_rst_rsp", ok, 1);
    check("post_rst_first_id", rsp_id, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // random traffic; monitor scores every grant and response
    for (int i = 0; i < 300; i++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = W'($urandom_range(0, 255)); req0_b = W'($urandom_range(0, 255));
      req1_a = W'($urandom_range(0, 255)); req1_b = W'($urandom_range(0, 255));
      req0_op = 2'($urandom_range(0, 3)); req1_op = 2'($urandom_range(0, 3));
      ena = ($urandom_range(0, 7) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; ena = 1'b1; rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
